refclk_source_select: RTL and testbench

Reference-clock source selector for the desk clock: it supplies the 32.768 kHz reference that feeds the clock top level's `i_refclk` input. It watches an external 32.768 kHz crystal input and forwards it while it is healthy. If the crystal is missing or stalls, it falls back to a numerically controlled oscillator (NCO) derived from the system clock, and it switches between the two sources without producing runt pulses. The output is a registered level in the `i_clk` domain, and the clock top level resynchronizes it downstream.

---
 rtl/refclk_source_select.sv | 150 +++++++++++++++
 tb/tb_refclk_source_select.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/refclk_source_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : refclk_source_select
// Purpose  : Picks the 32.768 kHz desk-clock reference. A healthy external
//            crystal is forwarded. A missing or stalled crystal is replaced by
//            an NCO running from i_clk. Switch-over never emits a runt pulse.
// Revision : 1.0 - initial release
// ============================================================================
module refclk_source_select #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int REF_FREQ       = 32_768,
  parameter int ACC_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GOOD_EDGES     = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_refclk_ext,
  output logic o_refclk,
  output logic o_ext_active,
  output logic o_fail_stb
);

  // Rounded NCO increment: round(2^ACC_WIDTH * REF_FREQ / CLK_FREQ)
  localparam longint c_INC_L = ((longint'(1) << ACC_WIDTH) * longint'(REF_FREQ)
                               + longint'(CLK_FREQ) / 2) / longint'(CLK_FREQ);
  localparam logic [ACC_WIDTH-1:0] c_INC  = ACC_WIDTH'(c_INC_L);
  localparam logic [ACC_WIDTH-1:0] c_HALF = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  localparam int                   c_WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0]    c_WD_MAX   = c_WD_W'(TIMEOUT_CYCLES);
  localparam logic [c_WD_W-1:0]    c_WD_ONE   = c_WD_W'(1);
  localparam int                   c_GOOD_W   = $clog2(GOOD_EDGES + 1);
  localparam logic [c_GOOD_W-1:0]  c_GOOD_MAX = c_GOOD_W'(GOOD_EDGES);
  localparam logic [c_GOOD_W-1:0]  c_GOOD_ONE = c_GOOD_W'(1);

  localparam logic [1:0] c_ST_INT  = 2'd0;
  localparam logic [1:0] c_ST_PEND = 2'd1;
  localparam logic [1:0] c_ST_EXT  = 2'd2;

  logic                 s1_q, s2_q, s3_q;
  logic [c_WD_W-1:0]    wd_q, wd_d;
  logic [c_GOOD_W-1:0]  good_q, good_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [1:0]           state_q, state_d;
  logic                 ref_q, ref_d;
  logic                 stb_q, stb_d;

  logic ext_rise;
  logic wd_late;
  logic timeout;
  logic nco_out;

  assign ext_rise = s2_q & ~s3_q;
  assign wd_late  = (wd_q == c_WD_MAX);
  // An edge landing exactly on the limit rescues the source.
  assign timeout  = wd_late & ~ext_rise;
  assign nco_out  = acc_q[ACC_WIDTH-1];

  // Synchronize the external clock and keep one cycle of history for edge detect
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_refclk_ext;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Watchdog: cycles since the last external rise, saturating at the limit
  always_comb begin
    wd_d = wd_q;
    if (ext_rise)      wd_d = '0;
    else if (!wd_late) wd_d = wd_q + c_WD_ONE;
  end

  // Good-edge count: in-time edges add one, a late edge restarts the count at one
  always_comb begin
    good_d = good_q;
    if (timeout) begin
      good_d = '0;
    end else if (ext_rise) begin
      if (wd_late)                   good_d = c_GOOD_ONE;
      else if (good_q != c_GOOD_MAX) good_d = good_q + c_GOOD_ONE;
    end
  end

  // Source-selection FSM, output level and NCO phase handling
  always_comb begin
    state_d = state_q;
    ref_d   = nco_out;
    stb_d   = 1'b0;
    acc_d   = acc_q + c_INC;
    case (state_q)
      c_ST_INT: begin
        if (good_q == c_GOOD_MAX) state_d = c_ST_PEND;
      end
      c_ST_PEND: begin
        // Only hand over while the NCO is low so the rising edge is clean
        if (timeout) begin
          state_d = c_ST_INT;
        end else if (ext_rise && !nco_out) begin
          state_d = c_ST_EXT;
          ref_d   = 1'b1;
        end
      end
      c_ST_EXT: begin
        if (timeout) begin
          // Hold the level and seed the NCO so it continues from it
          state_d = c_ST_INT;
          stb_d   = 1'b1;
          ref_d   = ref_q;
          acc_d   = ref_q ? c_HALF : '0;
        end else begin
          ref_d = s2_q;
        end
      end
      default: state_d = c_ST_INT;
    endcase
  end

  // State, counters, NCO and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wd_q    <= '0;
      good_q  <= '0;
      acc_q   <= '0;
      state_q <= c_ST_INT;
      ref_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      good_q  <= good_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      ref_q   <= ref_d;
      stb_q   <= stb_d;
    end
  end

  assign o_refclk     = ref_q;
  assign o_ext_active = (state_q == c_ST_EXT);
  assign o_fail_stb   = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_refclk_source_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_refclk_source_select
// Purpose  : Randomized self-checking bench for refclk_source_select with a
//            cycle-level behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_refclk_source_select;

  localparam int     T_LIM = 4096;
  localparam int     G_LIM = 4;
  localparam longint INC   = 10995;
  localparam longint HALF  = 64'd8388608;
  localparam longint MOD   = 64'd16777216;
  localparam int     M_INT = 0, M_PEND = 1, M_EXT = 2;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_refclk_ext;
  logic o_refclk, o_ext_active, o_fail_stb;

  refclk_source_select dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_refclk_ext (i_refclk_ext),
    .o_refclk     (o_refclk),
    .o_ext_active (o_ext_active),
    .o_fail_stb   (o_fail_stb)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit [2:0] hist;
  int       m_wd, m_good, m_mode;
  longint   m_acc;
  bit       m_ref, m_stb;

  // Generator and monitors
  int  gen_p, gen_c;
  bit  gen_on, gen_hold, ext_rose;
  bit  drv[$];
  int  mm, stb_cnt, act_cnt, lat_err, cyc, last_chg, min_w;
  bit  last_ref, act_at_last;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist = 3'b000; m_wd = 0; m_good = 0; m_mode = M_INT;
    m_acc = 0; m_ref = 1'b0; m_stb = 1'b0;
  endtask

  // One clock of behaviour; hist[0] is the newest sample of the external input
  task automatic model_step(input bit x);
    bit rise, late, to, nco;
    int nwd, ngood;
    longint nacc;
    rise = hist[1] && !hist[2];
    late = (m_wd == T_LIM);
    to   = late && !rise;
    nco  = (m_acc >= HALF);
    nwd  = rise ? 0 : ((m_wd < T_LIM) ? m_wd + 1 : T_LIM);
    if (to)        ngood = 0;
    else if (rise) ngood = late ? 1 : ((m_good < G_LIM) ? m_good + 1 : G_LIM);
    else           ngood = m_good;
    nacc  = (m_acc + INC) % MOD;
    m_stb = 1'b0;
    if (m_mode == M_INT) begin
      m_ref = nco;
      if (m_good == G_LIM) m_mode = M_PEND;
    end else if (m_mode == M_PEND) begin
      m_ref = nco;
      if (to) m_mode = M_INT;
      else if (rise && !nco) begin m_mode = M_EXT; m_ref = 1'b1; end
    end else begin
      if (to) begin
        m_mode = M_INT; m_stb = 1'b1;
        nacc = m_ref ? HALF : 0;
      end else begin
        m_ref = hist[1];
      end
    end
    m_wd = nwd; m_good = ngood; m_acc = nacc;
    hist = {hist[1:0], x};
  endtask

  // Advance one clock: model at the edge, observe at the falling edge, drive next input
  task automatic tick();
    @(posedge i_clk);
    drv.push_back(i_refclk_ext);
    if (drv.size() > 4) void'(drv.pop_front());
    if (i_reset) model_reset(); else model_step(i_refclk_ext);
    @(negedge i_clk);
    cyc++;
    if (o_refclk !== m_ref || o_ext_active !== (m_mode == M_EXT) || o_fail_stb !== m_stb) mm++;
    if (o_fail_stb)   stb_cnt++;
    if (o_ext_active) act_cnt++;
    if (o_ext_active && drv.size() >= 3 && o_refclk !== drv[drv.size()-3]) lat_err++;
    if (o_refclk !== last_ref) begin
      if (o_ext_active && act_at_last && (cyc - last_chg) < min_w) min_w = cyc - last_chg;
      last_chg = cyc; last_ref = o_refclk; act_at_last = o_ext_active;
    end
    ext_rose = 1'b0;
    if (gen_on && !gen_hold) begin
      gen_c        = (gen_c + 1) % gen_p;
      i_refclk_ext = (gen_c < gen_p / 2);
      ext_rose     = (gen_c == 0);
    end
  endtask

  task automatic wait_ext_rise();
    int n = 0;
    while (!ext_rose && n < 6000) begin tick(); n++; end
    check("gen_rise_seen", ext_rose, 1);
  endtask

  task automatic wait_lock(input string tag);
    int edges = 0;
    int n = 0;
    while (!o_ext_active && n < 20000) begin
      tick(); n++;
      if (ext_rose) edges++;
    end
    check({tag, "_locked"}, o_ext_active, 1);
    check({tag, "_edges_ge4"}, (edges >= 4), 1);
  endtask

  task automatic new_fast_period();
    gen_p = $urandom_range(1000, 1150);
    gen_c = gen_c % gen_p;
  endtask

  initial begin
    int     n, rises, fail_at;
    bit     prev, ref_at_fail;
    longint exp_rises;
    min_w = 1 << 30; cyc = 0; last_chg = 0; last_ref = 1'b0; act_at_last = 1'b0;
    mm = 0; stb_cnt = 0; act_cnt = 0; lat_err = 0;

    // Reset held while the external input toggles
    i_reset = 1'b1; i_refclk_ext = 1'b1;
    gen_on = 1'b1; gen_hold = 1'b0; gen_p = 40; gen_c = 0;
    model_reset();
    for (int i = 0; i < 50; i++) tick();
    check("reset_o_refclk", o_refclk, 0);
    check("reset_ext_active", o_ext_active, 0);
    check("reset_fail_stb", o_fail_stb, 0);
    check("reset_hold_model", mm, 0);

    // Free-running NCO with no external clock
    gen_on = 1'b0; i_refclk_ext = 1'b0; i_reset = 1'b0;
    mm = 0; act_cnt = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (o_refclk && !prev) rises++;
      prev = o_refclk;
    end
    exp_rises = (longint'(7999) * INC + HALF) / MOD;
    check("nco_rise_count", rises, exp_rises);
    check("nco_ext_active_never", act_cnt, 0);
    check("nco_model", mm, 0);

    // Lock onto a healthy external clock with random period and phase
    gen_p = $urandom_range(1000, 1150); gen_c = $urandom_range(0, gen_p - 1);
    gen_on = 1'b1; mm = 0;
    wait_lock("lock");
    lat_err = 0; min_w = 1 << 30; stb_cnt = 0;
    for (int i = 0; i < 4000; i++) tick();
    check("lock_latency_errors", lat_err, 0);
    check("lock_min_pulse_ge450", (min_w >= 450), 1);
    check("lock_no_strobe", stb_cnt, 0);
    check("lock_model", mm, 0);

    // Edge arriving exactly when the watchdog reaches its limit keeps EXT
    wait_ext_rise();
    gen_p = T_LIM + 1; stb_cnt = 0; mm = 0;
    for (int i = 0; i < 2 * (T_LIM + 1); i++) tick();
    check("bound_keep_ext", o_ext_active, 1);
    check("bound_keep_no_stb", stb_cnt, 0);
    // One cycle later than that is a fallback
    wait_ext_rise();
    gen_p = T_LIM + 2; stb_cnt = 0;
    for (int i = 0; i < 2 * (T_LIM + 2); i++) tick();
    check("bound_fall_int", o_ext_active, 0);
    check("bound_fall_one_stb", stb_cnt, 1);
    check("bound_model", mm, 0);

    // Stall high from EXT
    new_fast_period();
    wait_lock("relock1");
    wait_ext_rise();
    gen_hold = 1'b1; stb_cnt = 0; mm = 0; fail_at = -1; ref_at_fail = 1'b0; n = 0;
    while (fail_at < 0 && n < 4400) begin
      tick(); n++;
      if (o_fail_stb) begin fail_at = n; ref_at_fail = o_refclk; end
    end
    check("stall_fail_seen", (fail_at >= 0), 1);
    check("stall_ext_active_low", o_ext_active, 0);
    check("stall_ref_held_high", ref_at_fail, 1);
    // The NCO is seeded at its half-way point, so the high phase ends within one half-period
    n = 0;
    while (o_refclk && n < 1000) begin tick(); n++; end
    check("stall_fall_within_half", (n <= 764), 1);
    check("stall_stb_once", stb_cnt, 1);
    check("stall_model", mm, 0);

    // External clock too slow: never leaves INT
    gen_hold = 1'b0; gen_p = 5000; gen_c = 0;
    stb_cnt = 0; act_cnt = 0; mm = 0;
    for (int i = 0; i < 12000; i++) tick();
    check("slow_never_ext", act_cnt, 0);
    check("slow_no_stb", stb_cnt, 0);
    check("slow_model", mm, 0);

    // Reset pulse while in EXT, then relock
    new_fast_period();
    wait_lock("relock2");
    for (int i = 0; i < 300; i++) tick();
    i_reset = 1'b1;
    model_reset();
    #1;
    check("rstmid_o_refclk", o_refclk, 0);
    check("rstmid_ext_active", o_ext_active, 0);
    check("rstmid_fail_stb", o_fail_stb, 0);
    tick();
    i_reset = 1'b0; mm = 0;
    wait_lock("rstmid_relock");
    check("rstmid_model", mm, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
